// File: rtl/gx400_priority_mixer.sv
// gx400_priority_mixer: per-layer attribute delay lines, object latch and priority resolve into a colour-RAM address; GX400_PRI_LAYER_MASK_EN adds i_LAYER_MASK
module gx400_priority_mixer #(
  parameter int NUM_TM   = 2,
  parameter int DEPTH    = 3,
  parameter int FLIP_STG = 2,
  parameter int COLW     = 7,
  parameter int PXW      = 4,
  parameter int PRW      = 4,
  parameter int ADDRW    = 11
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_CEN6,
  input  logic [NUM_TM*DEPTH-1:0] i_STG_STB,
  input  logic [NUM_TM*PRW-1:0]   i_TILE_PRI,
  input  logic [NUM_TM-1:0]       i_VHFF,
  input  logic [NUM_TM*COLW-1:0]  i_TILE_COL,
  input  logic [NUM_TM*PXW-1:0]   i_TM_PX,
  input  logic [NUM_TM-1:0]       i_TM_OPQ,
  input  logic [2*ADDRW-1:0]      i_OBJ_PX,
  input  logic                    i_OBJ_LD,
  input  logic [PRW-1:0]          i_OBJ_PRI,
  input  logic                    i_HFLIP,
`ifdef GX400_PRI_LAYER_MASK_EN
  input  logic [NUM_TM:0]         i_LAYER_MASK,
`endif
  output logic [NUM_TM-1:0]       o_TM_HFLIP,
  output logic [ADDRW-1:0]        o_CRAM_ADDR,
  output logic [2:0]              o_WIN
);
  if (ADDRW != COLW + PXW || NUM_TM > 4 || FLIP_STG > DEPTH) begin : g_bad_cfg
    $error("gx400_priority_mixer: illegal parameter combination");
  end
  logic [NUM_TM:0] mask;
`ifdef GX400_PRI_LAYER_MASK_EN
  assign mask = i_LAYER_MASK;
`else
  assign mask = '0;
`endif
  logic [PRW-1:0]  last_pri [NUM_TM];
  logic [COLW-1:0] last_col [NUM_TM];
  genvar k;
  for (k = 0; k < NUM_TM; k++) begin : g_tm
    logic [DEPTH-1:0][PRW-1:0]  pri_q;
    logic [DEPTH-1:0][COLW-1:0] col_q;
    logic [FLIP_STG-1:0]        vh_q;
    // all stages update from pre-edge values, so simultaneous strobes shift rather than fall through
    always_ff @(posedge i_CLK) begin
      if (i_RST) begin
        pri_q <= '0;
        col_q <= '0;
        vh_q  <= '0;
      end else begin
        if (i_STG_STB[k*DEPTH]) begin
          pri_q[0] <= i_TILE_PRI[k*PRW +: PRW];
          col_q[0] <= i_TILE_COL[k*COLW +: COLW];
          vh_q[0]  <= i_VHFF[k];
        end
        for (int s = 1; s < DEPTH; s++)
          if (i_STG_STB[k*DEPTH+s]) begin
            pri_q[s] <= pri_q[s-1];
            col_q[s] <= col_q[s-1];
          end
        for (int s = 1; s < FLIP_STG; s++)
          if (i_STG_STB[k*DEPTH+s]) vh_q[s] <= vh_q[s-1];
      end
    end
    assign last_pri[k]   = pri_q[DEPTH-1];
    assign last_col[k]   = col_q[DEPTH-1];
    assign o_TM_HFLIP[k] = vh_q[FLIP_STG-1];
  end
  logic [2*ADDRW-1:0] obj_q;
  logic [ADDRW-1:0]   obj, addr_d, addr_q;
  logic [2:0]         win_d, win_q;
  logic [PRW:0]       best;
  logic               hit;
  always_ff @(posedge i_CLK) begin
    if (i_RST) obj_q <= '0;
    else if (i_OBJ_LD) obj_q <= i_OBJ_PX;
  end
  // object scores carry a 1 in the LSB so it wins ties; strict compare keeps the lowest tile index
  always_comb begin
    obj    = (~i_OBJ_LD ^ i_HFLIP) ? obj_q[2*ADDRW-1:ADDRW] : obj_q[ADDRW-1:0];
    best   = {i_OBJ_PRI, 1'b1};
    hit    = (|obj[PXW-1:0]) & ~mask[NUM_TM];
    win_d  = 3'd7;
    addr_d = obj;
    for (int i = 0; i < NUM_TM; i++)
      if (i_TM_OPQ[i] && !mask[i] && (!hit || {last_pri[i], 1'b0} > best)) begin
        best   = {last_pri[i], 1'b0};
        hit    = 1'b1;
        win_d  = 3'(i);
        addr_d = {last_col[i], i_TM_PX[i*PXW +: PXW]};
      end
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      addr_q <= '0;
      win_q  <= 3'd7;
    end else if (i_CEN6) begin
      addr_q <= addr_d;
      win_q  <= win_d;
    end
  end
  assign o_CRAM_ADDR = addr_q;
  assign o_WIN       = win_q;
endmodule

// File: tb/tb_gx400_priority_mixer.sv
// tb_gx400_priority_mixer: directed vectors with hand-computed expectations for the default (unmasked) build
module tb_gx400_priority_mixer;
  localparam int NT = 2, D = 3, CW = 7, PW = 4, RW = 4, AW = 11;
  logic            clk = 1'b0;
  logic            rst, cen6, obj_ld, hflip;
  logic [NT*D-1:0] stb;
  logic [NT*RW-1:0] tpri;
  logic [NT-1:0]   vhff, opq, tm_hflip;
  logic [NT*CW-1:0] tcol;
  logic [NT*PW-1:0] tpx;
  logic [2*AW-1:0] obj_px;
  logic [RW-1:0]   obj_pri;
  logic [AW-1:0]   addr;
  logic [2:0]      win;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  gx400_priority_mixer dut (
    .i_CLK(clk), .i_RST(rst), .i_CEN6(cen6), .i_STG_STB(stb),
    .i_TILE_PRI(tpri), .i_VHFF(vhff), .i_TILE_COL(tcol), .i_TM_PX(tpx),
    .i_TM_OPQ(opq), .i_OBJ_PX(obj_px), .i_OBJ_LD(obj_ld), .i_OBJ_PRI(obj_pri),
    .i_HFLIP(hflip), .o_TM_HFLIP(tm_hflip), .o_CRAM_ADDR(addr), .o_WIN(win)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [NT*D-1:0] s, input logic c);
    stb  = s;
    cen6 = c;
    tick();
    stb  = '0;
    cen6 = 1'b0;
  endtask
  task automatic set_tile(input int k, input logic [RW-1:0] p, input logic [CW-1:0] c, input logic v);
    tpri[k*RW +: RW] = p;
    tcol[k*CW +: CW] = c;
    vhff[k]          = v;
  endtask
  task automatic latch_obj(input logic [AW-1:0] b, input logic [AW-1:0] a);
    obj_px = {b, a};
    obj_ld = 1'b1;
    tick();
    obj_ld = 1'b0;
  endtask
  task automatic chk_out(input string tag, input logic [AW-1:0] a, input logic [2:0] w);
    pulse('0, 1'b1);
    check({tag, "_addr"}, 32'(addr), 32'(a));
    check({tag, "_win"}, 32'(win), 32'(w));
  endtask
  initial begin
    rst = 1'b1; stb = '1; cen6 = 1'b1; obj_ld = 1'b1; hflip = 1'b0;
    tpri = '1; vhff = '1; tcol = '1; tpx = '1; opq = '1; obj_px = '1; obj_pri = '1;
    tick();
    tick();
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_win", 32'(win), 32'd7);
    check("rst_hflip", 32'(tm_hflip), 32'h0);
    rst = 1'b0; stb = '0; cen6 = 1'b0; obj_ld = 1'b0; obj_px = '0;
    tpri = '0; vhff = '0; tcol = '0; tpx = '0; opq = '0; obj_pri = '0;
    set_tile(0, 4'h3, 7'h55, 1'b1);
    tpx[3:0] = 4'hA;
    opq[0]   = 1'b1;
    pulse(6'b000001, 1'b0);
    check("hflip_s0", 32'(tm_hflip), 32'h0);
    chk_out("shift1", 11'h00A, 3'd0);
    pulse(6'b000010, 1'b0);
    check("hflip_s1", 32'(tm_hflip), 32'h1);
    chk_out("shift2", 11'h00A, 3'd0);
    pulse(6'b000100, 1'b0);
    chk_out("shift3", 11'h55A, 3'd0);
    set_tile(0, 4'h5, 7'h2A, 1'b1);
    pulse(6'b000111, 1'b0);
    chk_out("true_shift", 11'h55A, 3'd0);
    set_tile(0, 4'h5, 7'h55, 1'b1);
    repeat (3) pulse(6'b000111, 1'b0);
    latch_obj(11'h123, 11'h000);
    obj_pri = 4'h4;
    chk_out("tile_beats_obj", 11'h55A, 3'd0);
    obj_pri = 4'h5;
    chk_out("obj_wins_tie", 11'h123, 3'd7);
    latch_obj(11'h000, 11'h000);
    set_tile(0, 4'h2, 7'h55, 1'b1);
    repeat (3) pulse(6'b000111, 1'b0);
    set_tile(1, 4'h2, 7'h33, 1'b0);
    tpx[7:4] = 4'h7;
    opq = 2'b11;
    repeat (3) pulse(6'b111000, 1'b0);
    chk_out("tie_l0", 11'h55A, 3'd0);
    opq = 2'b10;
    chk_out("tie_l1", 11'h337, 3'd1);
    opq = 2'b00;
    latch_obj(11'h7F0, 11'h000);
    chk_out("backdrop", 11'h7F0, 3'd7);
    opq = 2'b10;
    set_tile(1, 4'h9, 7'h44, 1'b0);
    pulse(6'b001000, 1'b0);
    pulse(6'b010000, 1'b0);
    pulse(6'b100000, 1'b1);
    check("collide_addr", 32'(addr), 32'h337);
    chk_out("post_collide", 11'h447, 3'd1);
    opq = 2'b00;
    latch_obj(11'h2F1, 11'h1E2);
    hflip = 1'b0;
    chk_out("mux_b", 11'h2F1, 3'd7);
    hflip = 1'b1;
    chk_out("mux_a", 11'h1E2, 3'd7);
    hflip = 1'b0;
    pulse('0, 1'b0);
    check("hold_addr", 32'(addr), 32'h1E2);
    obj_ld = 1'b1;
    chk_out("mux_ld", 11'h1E2, 3'd7);
    obj_ld = 1'b0;
    opq = 2'b10;
    obj_pri = 4'h8;
    chk_out("tile_hi_pri", 11'h447, 3'd1);
    obj_pri = 4'hA;
    chk_out("obj_hi_pri", 11'h2F1, 3'd7);
    check("hflip_pre_rst", 32'(tm_hflip), 32'h1);
    rst = 1'b1; stb = '1; cen6 = 1'b1;
    tick();
    rst = 1'b0; stb = '0; cen6 = 1'b0;
    check("rst2_addr", 32'(addr), 32'h0);
    check("rst2_win", 32'(win), 32'd7);
    check("rst2_hflip", 32'(tm_hflip), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
